multicycle_core: RTL and testbench

- Parametrised multi-cycle RV32I-subset core; next generation of the single-cycle CPU top.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK through an explicit FSM, with a single unified memory port using a req/ready handshake.
- Adds an internal register file, halt and illegal-instruction trap, and RV32E (16-register) mode.
- Sits between the system memory and the debug/halt controller.

---
 rtl/multicycle_core.sv | 262 ++++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV32E-subset core. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// over a single req/ready memory port, and adds halt and a sticky illegal-instruction trap.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_o,
  output logic        retired,
  output logic        halted,
  output logic        trap
);
  localparam int AW = (NREGS == 32) ? 5 : 4;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALTED, S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] st_data_q, st_data_d, result_q, result_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic        retired_q, retired_d, halted_q, halted_d, trap_q, trap_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_op, is_lui, is_load, is_store, uses_rs2, regs_ok, alt;
  logic [31:0] imm, ea;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign is_op    = (opcode == OP_REG);
  assign is_lui   = (opcode == OP_LUI);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign uses_rs2 = is_op || is_store;
  assign regs_ok  = (is_lui || reg_ok(rs1)) && (!uses_rs2 || reg_ok(rs2)) && (is_store || reg_ok(rd));
  assign alt      = ir_q[30] && (is_op || (funct3 == 3'b101));
  assign ea       = op_a_q + op_b_q;

  // In RV32E mode only indices 0..15 exist.
  function automatic logic reg_ok(input logic [4:0] idx);
    reg_ok = (NREGS == 32) || (idx[4] == 1'b0);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    rf_read = (idx == 5'd0) ? 32'd0 : rf_q[idx[AW-1:0]];
  endfunction

  function automatic logic legal(input logic [31:0] ir);
    case (ir[6:0])
      OP_REG:  legal = (ir[31:25] == 7'h00) ||
                       ((ir[31:25] == 7'h20) && ((ir[14:12] == 3'b000) || (ir[14:12] == 3'b101)));
      OP_IMM:  legal = (ir[14:12] == 3'b001) ? (ir[31:25] == 7'h00) :
                       (ir[14:12] == 3'b101) ? ((ir[31:25] == 7'h00) || (ir[31:25] == 7'h20)) : 1'b1;
      OP_LUI:  legal = 1'b1;
      OP_LOAD, OP_STORE: legal = (ir[14:12] == 3'b010);
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub_sra,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = sub_sra ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = sub_sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: alu = 32'd0;
    endcase
  endfunction

  // Immediate formation: S-type for stores, U-type for LUI, I-type otherwise.
  always_comb begin
    imm = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_STORE: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_LUI:   imm = {ir_q[31:12], 12'd0};
      default:  imm = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // Next-state and next-output logic for the instruction sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    st_data_d   = st_data_q;
    result_d    = result_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retired_d   = 1'b0;
    halted_d    = halted_q;
    trap_d      = trap_q;
    rf_d        = rf_q;
    case (state_q)
      S_FETCH: begin
        // Right after reset the request flop is still low, so raise it first.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!legal(ir_q) || !regs_ok) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          op_a_d    = is_lui ? 32'd0 : rf_read(rs1);
          op_b_d    = is_op ? rf_read(rs2) : imm;
          st_data_d = rf_read(rs2);
          state_d   = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_load || is_store) begin
          if (ea[1:0] != 2'b00) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = ea;
            mem_wdata_d = is_store ? st_data_q : 32'd0;
            state_d     = S_MEM;
          end
        end else begin
          result_d  = is_lui ? op_b_q : alu(funct3, alt, op_a_q, op_b_q);
          retired_d = 1'b1;
          state_d   = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          result_d    = is_load ? mem_rdata : result_q;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = 32'd0;
          retired_d   = 1'b1;
          state_d     = S_WRITEBACK;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WRITEBACK: begin
        if (!is_store && (rd != 5'd0)) begin
          rf_d[rd[AW-1:0]] = result_q;
        end else begin
          rf_d = rf_q;
        end
        pc_d = pc_q + 32'd4;
        if (halt) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q + 32'd4;
          state_d    = S_FETCH;
        end
      end
      S_HALTED: begin
        if (!halt) begin
          halted_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
          state_d    = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  // State, datapath and register-file flops; reset aborts any bus transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      st_data_q   <= 32'd0;
      result_q    <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= 32'd0;
      retired_q   <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      st_data_q   <= st_data_d;
      result_q    <= result_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
      rf_q        <= rf_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_o      = pc_q;
  assign retired   = retired_q;
  assign halted    = halted_q;
  assign trap      = trap_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: table of single-instruction ALU vectors plus
// hand-written sequences for wait states, halt, traps, RV32E and mid-transaction reset.
module tb_multicycle_core;
  logic        clock, reset, halt, mem_req, mem_we, mem_ready, retired, halted, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
  logic        e_req, e_we, e_ready, e_retired, e_halted, e_trap, e_halt;
  logic [31:0] e_addr, e_wdata, e_instr, e_pc;

  multicycle_core #(.RESET_PC(32'h0000_0040), .NREGS(32)) dut (
    .clock(clock), .reset(reset), .halt(halt), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_o(pc_o), .retired(retired), .halted(halted), .trap(trap));

  multicycle_core #(.NREGS(16)) dut16 (
    .clock(clock), .reset(reset), .halt(e_halt), .mem_req(e_req), .mem_we(e_we),
    .mem_addr(e_addr), .mem_wdata(e_wdata), .mem_rdata(e_instr), .mem_ready(e_ready),
    .pc_o(e_pc), .retired(e_retired), .halted(e_halted), .trap(e_trap));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] instr; logic [31:0] exp; } vec_t;
  vec_t vecs[21];

  logic [31:0] mem [64];
  logic [31:0] wr_addr_log [8];
  logic [31:0] wr_data_log [8];
  int retire_cyc [64];
  int checks = 0, failures = 0;
  int cyc, retire_n, e_ret_n, txn_n, wr_n, stab_err, wcnt, waits, bad, n;
  logic        prev_req, prev_ready, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [11:0] off);
    return enc_i(off, 5'd0, 3'b010, rd, 7'h03);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, track bus stability and retires, then answer the bus.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (mem_req && prev_req && !prev_ready &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata)) stab_err++;
    if (retired) begin
      if (retire_n < 64) retire_cyc[retire_n] = cyc;
      retire_n++;
    end
    if (e_retired) e_ret_n++;
    if (mem_req) begin
      if (wcnt >= waits) begin
        mem_ready = 1'b1;
        wcnt = 0;
        txn_n++;
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          if (wr_n < 8) begin
            wr_addr_log[wr_n] = mem_addr;
            wr_data_log[wr_n] = mem_wdata;
          end
          wr_n++;
        end else begin
          mem_rdata = mem[mem_addr[7:2]];
        end
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
    prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
    prev_ready = mem_ready;
  endtask

  task automatic clear_model();
    mem_ready = 1'b0; wcnt = 0; prev_req = 1'b0; prev_ready = 1'b0;
    cyc = 0; retire_n = 0; e_ret_n = 0; txn_n = 0; wr_n = 0; stab_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    halt = 1'b0;
    repeat (2) @(negedge clock);
    clear_model();
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic run_until_trap(input string name, input int limit);
    n = 0;
    while (!trap && n < limit) begin
      step();
      n++;
    end
    check(name, {31'd0, trap}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    e_ready = 1'b1; e_halt = 1'b0; e_instr = 32'd0; waits = 0;
    clear_model();
    clear_mem();

    vecs[0]  = '{32'd5,          32'hFFFF_FFFD, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd2};
    vecs[1]  = '{32'd5,          32'd7,         enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFE};
    vecs[2]  = '{32'd1,          32'h25,        enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'h20};
    vecs[3]  = '{32'hFFFF_FFFD,  32'd5,         enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd1};
    vecs[4]  = '{32'hFFFF_FFFD,  32'd5,         enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3), 32'd0};
    vecs[5]  = '{32'hF0F0_F0F0,  32'h0FF0_0FF0, enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hFF00_FF00};
    vecs[6]  = '{32'h8000_0000,  32'd4,         enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3), 32'h0800_0000};
    vecs[7]  = '{32'h8000_0000,  32'd4,         enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3), 32'hF800_0000};
    vecs[8]  = '{32'h1234_0000,  32'h0000_5678, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'h1234_5678};
    vecs[9]  = '{32'hFF00_FF00,  32'h0F0F_0F0F, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'h0F00_0F00};
    vecs[10] = '{32'h7FFF_FFFF,  32'd0, enc_i(12'h001, 5'd1, 3'b000, 5'd3, 7'h13), 32'h8000_0000};
    vecs[11] = '{32'hFFFF_FFFF,  32'd0, enc_i(12'h000, 5'd1, 3'b010, 5'd3, 7'h13), 32'd1};
    vecs[12] = '{32'd1,          32'd0, enc_i(12'hFFF, 5'd1, 3'b011, 5'd3, 7'h13), 32'd1};
    vecs[13] = '{32'h0000_FFFF,  32'd0, enc_i(12'hFFF, 5'd1, 3'b100, 5'd3, 7'h13), 32'hFFFF_0000};
    vecs[14] = '{32'h0000_0100,  32'd0, enc_i(12'h0F0, 5'd1, 3'b110, 5'd3, 7'h13), 32'h0000_01F0};
    vecs[15] = '{32'h1234_5678,  32'd0, enc_i(12'h0FF, 5'd1, 3'b111, 5'd3, 7'h13), 32'h0000_0078};
    vecs[16] = '{32'd3,          32'd0, enc_i(12'h01F, 5'd1, 3'b001, 5'd3, 7'h13), 32'h8000_0000};
    vecs[17] = '{32'hFFFF_FFFF,  32'd0, enc_i(12'h01C, 5'd1, 3'b101, 5'd3, 7'h13), 32'h0000_000F};
    vecs[18] = '{32'h8000_0000,  32'd0, enc_i(12'h404, 5'd1, 3'b101, 5'd3, 7'h13), 32'hF800_0000};
    vecs[19] = '{32'd0,          32'd0, enc_u(20'hABCDE, 5'd3), 32'hABCD_E000};
    vecs[20] = '{32'hFFFF_FFFF,  32'd1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0};

    // Values while reset is held.
    @(negedge clock);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h40);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc_o, 32'h40);
    check("rst_flags", {29'd0, retired, halted, trap}, 32'd0);
    check("rst_pc_default", e_pc, 32'd0);
    do_reset();

    // Table: load operands, run one instruction, store x3, stop on opcode 0x7F.
    for (int i = 0; i < 21; i++) begin
      clear_mem();
      mem[16] = lw(5'd1, 12'h080);
      mem[17] = lw(5'd2, 12'h084);
      mem[18] = vecs[i].instr;
      mem[19] = enc_s(12'h088, 5'd3, 5'd0);
      mem[20] = 32'h0000_007F;
      mem[32] = vecs[i].a;
      mem[33] = vecs[i].b;
      mem[34] = 32'hDEAD_BEEF;
      waits = i % 2;
      do_reset();
      run_until_trap($sformatf("vec%0d_trap", i), 200);
      check($sformatf("vec%0d_result", i), mem[34], vecs[i].exp);
      check($sformatf("vec%0d_trap_pc", i), pc_o, 32'h50);
    end

    // ALU program with zero-wait memory: 4-cycle spacing and PC after the fifth retire.
    clear_mem();
    mem[16] = enc_i(12'h005, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[17] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13);
    mem[18] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[19] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4);
    mem[20] = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd5);
    mem[21] = enc_s(12'h090, 5'd3, 5'd0);
    mem[22] = enc_s(12'h094, 5'd4, 5'd0);
    mem[23] = enc_s(12'h098, 5'd5, 5'd0);
    mem[24] = 32'h0000_007F;
    mem[36] = 32'hDEAD_BEEF; mem[37] = 32'hDEAD_BEEF; mem[38] = 32'hDEAD_BEEF;
    waits = 0;
    do_reset();
    n = 0;
    while (retire_n < 5 && n < 60) begin
      step();
      n++;
    end
    check("alu_retire_count", retire_n, 32'd5);
    step();
    check("alu_pc_after_5", pc_o, 32'h54);
    for (int i = 1; i < 5; i++) check($sformatf("alu_interval%0d", i), retire_cyc[i] - retire_cyc[i-1], 32'd4);
    run_until_trap("alu_trap", 100);
    check("alu_x3", mem[36], 32'd2);
    check("alu_x4", mem[37], 32'd1);
    check("alu_x5", mem[38], 32'd0);

    // Two wait cycles on every transaction.
    clear_mem();
    mem[16] = enc_u(20'h00001, 5'd1);
    mem[17] = enc_s(12'h008, 5'd1, 5'd0);
    mem[18] = lw(5'd6, 12'h008);
    mem[19] = enc_s(12'h09C, 5'd6, 5'd0);
    mem[20] = 32'h0000_007F;
    waits = 2;
    do_reset();
    run_until_trap("wait_trap", 200);
    check("wait_wr_addr", wr_addr_log[0], 32'h8);
    check("wait_wr_data", wr_data_log[0], 32'h0000_1000);
    check("wait_x6", mem[39], 32'h0000_1000);
    check("wait_lw_cycles", retire_cyc[2] - retire_cyc[1], 32'd9);
    check("wait_bus_stable", stab_err, 32'd0);

    // Writes to x0 are discarded.
    clear_mem();
    mem[16] = enc_i(12'h007, 5'd0, 3'b000, 5'd0, 7'h13);
    mem[17] = enc_s(12'h0A0, 5'd0, 5'd0);
    mem[18] = 32'h0000_007F;
    mem[40] = 32'hDEAD_BEEF;
    waits = 0;
    do_reset();
    run_until_trap("x0_trap", 100);
    check("x0_reads_zero", mem[40], 32'd0);

    // Halt raised during the first fetch wait.
    clear_mem();
    mem[16] = enc_i(12'h001, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[17] = enc_i(12'h002, 5'd0, 3'b000, 5'd2, 7'h13);
    waits = 2;
    do_reset();
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    halt = 1'b1;
    n = 0;
    while (!halted && n < 40) begin
      step();
      n++;
    end
    check("halt_entered", {31'd0, halted}, 32'd1);
    check("halt_retired", retire_n, 32'd1);
    check("halt_pc", pc_o, 32'h44);
    bad = 0;
    repeat (5) begin
      step();
      if (mem_req) bad++;
    end
    check("halt_no_req", bad, 32'd0);
    halt = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    check("halt_resume_addr", mem_addr, 32'h44);
    check("halt_cleared", {31'd0, halted}, 32'd0);

    // Illegal shift encoding traps after one retired instruction.
    clear_mem();
    mem[16] = enc_i(12'h001, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[17] = enc_i(12'h401, 5'd1, 3'b001, 5'd1, 7'h13);
    waits = 0;
    do_reset();
    run_until_trap("ill_shift_trap", 100);
    check("ill_shift_pc", pc_o, 32'h44);
    check("ill_shift_retired", retire_n, 32'd1);

    // Misaligned load: trap with no data request, sticky until reset.
    clear_mem();
    mem[16] = lw(5'd1, 12'h002);
    do_reset();
    run_until_trap("misal_trap", 100);
    check("misal_txns", txn_n, 32'd1);
    check("misal_pc", pc_o, 32'h40);
    bad = 0;
    repeat (6) begin
      step();
      if (mem_req || !trap) bad++;
    end
    check("misal_sticky", bad, 32'd0);
    do_reset();
    check("misal_reset_trap", {31'd0, trap}, 32'd0);
    check("misal_reset_pc", pc_o, 32'h40);

    // RV32E: x1..x3 retire normally, x17 traps.
    e_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    do_reset();
    repeat (14) step();
    check("rv32e_retires", e_ret_n, 32'd3);
    check("rv32e_no_trap", {31'd0, e_trap}, 32'd0);
    e_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd17);
    do_reset();
    repeat (6) step();
    check("rv32e_x17_trap", {31'd0, e_trap}, 32'd1);
    check("rv32e_x17_retired", e_ret_n, 32'd0);
    check("rv32e_x17_pc", e_pc, 32'd0);

    // Asynchronous reset in the middle of a waited load.
    clear_mem();
    mem[16] = lw(5'd1, 12'h080);
    waits = 3;
    do_reset();
    n = 0;
    while (!(mem_req && mem_addr == 32'h80) && n < 30) begin
      step();
      n++;
    end
    check("areset_in_mem", mem_addr, 32'h80);
    #2 reset = 1'b1;
    #1;
    check("areset_req", {31'd0, mem_req}, 32'd0);
    check("areset_addr", mem_addr, 32'h40);
    check("areset_pc", pc_o, 32'h40);
    @(negedge clock);
    clear_model();
    reset = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    check("areset_refetch", mem_addr, 32'h40);
    check("areset_refetch_we", {31'd0, mem_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
